// File: rtl/dcm_seq_pkg.sv
// Shared definitions for the DCM/DLL reset sequencer: FSM state encoding,
// DCM STATUS bit positions and the saturating retry-counter helper.
package dcm_seq_pkg;

  // Sequencer states. The values are fixed so that debug tools and
  // register dumps can decode the 3-bit state directly.
  typedef enum logic [2:0] {
    DCM_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // DCM STATUS[2:0] bit positions.
  localparam int unsigned STATUS_PSOVF_BIT      = 0;  // phase-shift overflow, not used
  localparam int unsigned STATUS_CLKIN_STOP_BIT = 1;  // CLKIN stopped
  localparam int unsigned STATUS_CLKFX_STOP_BIT = 2;  // CLKFX stopped

  // Retry counter width and its saturation value.
  localparam int unsigned RETRY_W       = 8;
  localparam logic [7:0]  RETRY_SAT_VAL = 8'd255;

  // Increment the retry count, sticking at the saturation value.
  function automatic logic [7:0] retry_sat_inc(input logic [7:0] val);
    logic [7:0] res;
    if (val == RETRY_SAT_VAL) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level signals.
// Each bit is synchronised independently; no multi-bit coherency is implied.
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// DCM/DLL reset sequencer. Runs on the free-running oscillator (same net as
// DCM CLKIN), pulses DCM RST, waits for LOCKED to be stable, then releases the
// SoC reset. Lock loss or a stopped clock triggers an automatic relock, up to
// MAX_RETRIES consecutive failures, after which it parks in FAULT until a
// force_relock_i request or a hard reset.
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       dcm_locked_i,
  input  logic [2:0] dcm_status_i,
  input  logic       force_relock_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_n_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [7:0] retry_cnt_o
);

  // Counter reload values, one less than the cycle count because the counter
  // runs down to zero inclusive.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       MAX_RETRY_V = 8'(MAX_RETRIES);

  // Synchronised DCM indications
  logic [2:0] sync_in_s;
  logic [2:0] sync_out_s;
  logic       lk_s;
  logic       ci_stop_s;
  logic       fx_stop_s;
  logic       unused_ps_ovf_s;

  // FSM state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             fail_s;

  // Output registers
  logic dcm_rst_q, dcm_rst_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic locked_q, locked_d;
  logic fault_q, fault_d;

  // Phase-shift overflow carries no information for reset sequencing.
  assign unused_ps_ovf_s = dcm_status_i[STATUS_PSOVF_BIT];

  assign sync_in_s = {dcm_status_i[STATUS_CLKFX_STOP_BIT],
                      dcm_status_i[STATUS_CLKIN_STOP_BIT],
                      dcm_locked_i};

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b000)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (sync_in_s),
    .q_o     (sync_out_s)
  );

  assign lk_s      = sync_out_s[0];
  assign ci_stop_s = sync_out_s[1];
  assign fx_stop_s = sync_out_s[2];

  // State, shared down-counter and retry count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= DCM_RST;
      cnt_q   <= RST_LOAD;
      retry_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic: per-state progress first, then the overriding events
  // (force relock beats failure, failure beats counter expiry).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail_s  = 1'b0;

    case (state_q)
      DCM_RST: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = WAIT_LOCK;
          cnt_d   = LOCK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          fail_s = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RUN: begin
        if (!lk_s || ci_stop_s || fx_stop_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = DCM_RST;
        cnt_d   = RST_LOAD;
      end
    endcase

    if (force_relock_i && (state_q != DCM_RST)) begin
      // Operator request: restart without charging a failure. Only leaving
      // FAULT wipes the retry history.
      state_d = DCM_RST;
      cnt_d   = RST_LOAD;
      if (state_q == FAULT) begin
        retry_d = 8'd0;
      end else begin
        retry_d = retry_q;
      end
    end else if (fail_s) begin
      retry_d = retry_sat_inc(retry_q);
      if (retry_d > MAX_RETRY_V) begin
        state_d = FAULT;
      end else begin
        state_d = DCM_RST;
        cnt_d   = RST_LOAD;
      end
    end else if ((state_d == RUN) && (state_q != RUN)) begin
      // A successful lock forgives all earlier failed attempts.
      retry_d = 8'd0;
    end else begin
      retry_d = retry_q;
    end
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state itself.
  always_comb begin
    dcm_rst_d   = 1'b1;
    sys_rst_n_d = 1'b0;
    locked_d    = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      DCM_RST: begin
        dcm_rst_d = 1'b1;
      end
      WAIT_LOCK: begin
        dcm_rst_d = 1'b0;
      end
      STABLE: begin
        dcm_rst_d = 1'b0;
      end
      RUN: begin
        dcm_rst_d   = 1'b0;
        sys_rst_n_d = 1'b1;
        locked_d    = 1'b1;
      end
      FAULT: begin
        dcm_rst_d = 1'b1;
        fault_d   = 1'b1;
      end
      default: begin
        dcm_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
      end
    endcase
  end

  // Output flops: glitch-free outputs with no combinational input-to-output path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign locked_o    = locked_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: doc/dcm_reset_sequencer.md
Name: dcm_reset_sequencer

Overview:
- Sequences the DCM/DLL clock primitive: drives its asynchronous RST, watches LOCKED/STATUS, holds the SoC reset until the generated clock is stable.
- Recovers automatically from lock loss and stopped input clock, up to a bounded retry count.
- Clocked by the free-running board oscillator, which also feeds the DCM CLKIN. It is never clocked by the DCM output.
- Sits beside the clock-divider wrapper in the top level; its sys_rst_n_o feeds the SoC reset tree.

Parameters:
- RST_CYCLES, 8, cycles dcm_rst_o is held high per attempt (DCM minimum is 3 CLKIN cycles; legal range 3..255).
- LOCK_TIMEOUT, 65535, cycles to wait for LOCKED before retrying (range 1..2^20-1).
- STABLE_CYCLES, 1024, cycles LOCKED must stay high continuously before sys reset is released (range 1..2^16-1).
- MAX_RETRIES, 7, failed attempts tolerated before entering FAULT (range 1..255).
- CNT_W, 20, width of the shared down-counter; must cover the largest of the three cycle parameters.

Ports:
- clk_i, in, 1: oscillator clock (same net as the DCM CLKIN).
- rst_n_i, in, 1: asynchronous active-low reset.
- dcm_locked_i, in, 1: DCM LOCKED. Asynchronous to clk_i and synchronised internally.
- dcm_status_i, in, 3: DCM STATUS[2:0]. Bit1 = CLKIN stopped, bit2 = CLKFX stopped, bit0 = phase-shift overflow (ignored). Synchronised internally.
- force_relock_i, in, 1: single-cycle request to re-run the full sequence.
- dcm_rst_o, out, 1: DCM RST, active high.
- sys_rst_n_o, out, 1: SoC reset, active low.
- locked_o, out, 1: high only in RUN.
- fault_o, out, 1: retry budget exhausted.
- retry_cnt_o, out, 8: failed attempts since the last entry to RUN, saturating.

Behaviour:
- Synchroniser: dcm_locked_i and dcm_status_i[2:1] each pass through 2 flops. Reset value is 0. The FSM uses only the synchronised copies (lk, ci_stop, fx_stop).
- Reset (rst_n_i low, any time, mid-operation included):
  - state = DCM_RST, counter = RST_CYCLES-1, retry = 0.
  - dcm_rst_o = 1, sys_rst_n_o = 0, locked_o = 0, fault_o = 0.
- State DCM_RST:
  - dcm_rst_o = 1 for exactly RST_CYCLES cycles after entry.
  - Then go to WAIT_LOCK with counter = LOCK_TIMEOUT-1.
- State WAIT_LOCK:
  - dcm_rst_o = 0.
  - lk = 1: go to STABLE with counter = STABLE_CYCLES-1.
  - Else if counter == 0: timeout, treated as a failure (see below).
  - Else decrement the counter.
- State STABLE:
  - lk = 0: failure.
  - Counter reaches 0 with lk still 1: go to RUN.
- State RUN:
  - sys_rst_n_o = 1 and locked_o = 1, both registered and asserted on the first RUN cycle.
  - retry is cleared on entry.
  - lk = 0 or ci_stop = 1 or fx_stop = 1: go to DCM_RST. The failure rule applies, but the retry count already restarted at 0.
- Failure rule:
  - retry increments, saturating at 255.
  - If the new retry value is > MAX_RETRIES, go to FAULT. Otherwise go to DCM_RST with counter reload.
- State FAULT:
  - dcm_rst_o = 1, sys_rst_n_o = 0, fault_o = 1.
  - Exit only on force_relock_i, which clears retry and goes to DCM_RST, or on rst_n_i.
- force_relock_i in any state other than DCM_RST: go to DCM_RST with counter reload. Does not count as a failure.
- Simultaneous events:
  - force_relock_i has priority over a failure in the same cycle.
  - A failure has priority over the counter expiring.
- sys_rst_n_o = 0 in every state except RUN. It must deassert synchronously to clk_i; there is no combinational path from any input to any output.
- Latency:
  - LOCKED rising edge to locked_o: 2 sync cycles + STABLE_CYCLES + 1.
  - LOCKED falling edge in RUN to sys_rst_n_o low: 3 cycles.

Decomposition:
- Shared package dcm_seq_pkg holds:
  - state encoding: DCM_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, FAULT = 4; 3 bits.
  - STATUS bit index constants.
- One natural sub-module, sync_2ff: a parameterised-width 2-flop synchroniser, reusable elsewhere for asynchronous inputs.

Test Plan:
- Reset release with a DCM model that raises LOCKED 50 cycles after RST falls (RST_CYCLES = 8, STABLE_CYCLES = 16) -> dcm_rst_o high for exactly 8 cycles; locked_o and sys_rst_n_o go high 2+16+1 cycles after LOCKED rises; retry_cnt_o = 0.
- LOCKED never rises (LOCK_TIMEOUT = 100, MAX_RETRIES = 2) -> three RST pulses; retry_cnt_o steps 1, 2, 3; fault_o = 1 and dcm_rst_o stays high; force_relock_i then restarts the sequence with retry_cnt_o = 0.
- LOCKED glitches low for 1 cycle 10 cycles into STABLE -> return to DCM_RST; retry_cnt_o = 1; sys_rst_n_o never deasserts during the glitch.
- In RUN, STATUS[1] goes high -> sys_rst_n_o low 3 cycles later, then a new 8-cycle dcm_rst_o pulse; after relock, locked_o returns and retry_cnt_o = 0.
- force_relock_i in the same cycle as LOCKED loss in RUN -> DCM_RST entered; retry_cnt_o unchanged (no failure counted).
- rst_n_i asserted mid-WAIT_LOCK, asynchronously between clock edges -> all outputs take their reset values immediately, with no clock edge needed.
